// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Purpose  : Shares the single register-file write port among NREQ writeback
//            requesters. Fixed priority with starvation escalation, registered
//            RF write, and a 32-entry pending-write scoreboard that stalls
//            decode on RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int NREQ         = 3,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           chk_rs1,
    input  logic [4:0]           chk_rs2,
    input  logic [4:0]           chk_rd,
    output logic                 stall,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [XLEN-1:0]      rf_wdata
);

    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]   r_cnt [NREQ];
    logic [NREQ-1:0] w_starve;
    logic [NREQ-1:0] w_grant;
    logic            w_found;
    logic            w_xfer;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            r_rf_we;
    logic [4:0]      r_rf_rd;
    logic [XLEN-1:0] r_rf_wdata;
    logic [31:0]     r_pend;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    // A requester is starving once it has lost STARVE_LIMIT consecutive cycles
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_starve
            assign w_starve[gi] = req_valid[gi] && (r_cnt[gi] >= C_LIMIT);
        end
    endgenerate

    // One-hot grant: lowest starving index first, otherwise lowest valid index
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_starve[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign w_xfer    = |w_grant;
    assign req_ready = rst ? '0 : w_grant;

    // Select the winner's destination and data (grant is one-hot)
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = w_sel_rd   | req_rd[5*i +: 5];
                w_sel_data = w_sel_data | req_data[XLEN*i +: XLEN];
            end
        end
    end

    // Per-requester lost-cycle counters, saturating at the limit
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (flush || !req_valid[gi] || w_grant[gi]) begin
                    r_cnt[gi] <= '0;
                end else if (r_cnt[gi] < C_LIMIT) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // Output register; writes to x0 are accepted but never reach the RF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else if (w_xfer && (w_sel_rd != 5'd0)) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;

    assign w_set = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    assign w_clr = r_rf_we ? (32'd1 << r_rf_rd) : 32'd0;

    // Pending scoreboard: issue sets, RF commit clears, set wins a same-edge tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (flush) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
        end
    end

    assign stall = !rst && (r_pend[chk_rs1] || r_pend[chk_rs2] || r_pend[chk_rd]);

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scheduler
// Purpose  : Directed self-checking bench for rf_wb_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [4:0]           chk_rs1;
    logic [4:0]           chk_rs2;
    logic [4:0]           chk_rd;
    logic                 stall;
    logic                 rf_we;
    logic [4:0]           rf_rd;
    logic [XLEN-1:0]      rf_wdata;

    int errors = 0;
    int checks = 0;

    rf_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .stall(stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 3'b111; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        step(); step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rf_rd); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 3'b001; req_rd[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        step();
        req_valid = '0;
        #2;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd got=%0d exp=5", rf_rd); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got=%b exp=0", rf_we); end
    endtask

    task automatic test_priority();
        logic [2:0] exp_g [11];
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
        exp_g[4] = 3'b010; exp_g[5] = 3'b100; exp_g[6] = 3'b001; exp_g[7] = 3'b001;
        exp_g[8] = 3'b001; exp_g[9] = 3'b010; exp_g[10] = 3'b100;
        req_rd   = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        req_valid = 3'b111;
        for (int i = 0; i < 11; i++) begin
            #2;
            checks++;
            if (req_ready !== exp_g[i]) begin
                errors++; $display("FAIL prio_grant cycle=%0d got=%b exp=%b", i, req_ready, exp_g[i]);
            end
            if (i == 5) begin
                checks++;
                if (rf_rd !== 5'd2 || rf_wdata !== 32'h2222_0000) begin
                    errors++; $display("FAIL prio_rf cycle=5 got=%0d/%h exp=2/22220000", rf_rd, rf_wdata);
                end
            end
            step();
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_scoreboard();
        // RAW on rd=7 held until the commit edge
        chk_rs1 = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        req_valid = 3'b010; req_rd[9:5] = 5'd7; req_data[63:32] = 32'h7;
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_issued got=%b exp=1", stall); end
        step();
        req_valid = '0;
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_outreg got=%b exp=1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_cleared got=%b exp=0", stall); end
        // Re-issue on the commit edge: set wins
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        req_valid = 3'b010;
        step();
        req_valid = '0;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", stall); end
        // Drain rd=7 again
        req_valid = 3'b010;
        step();
        req_valid = '0;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_drain got=%b exp=0", stall); end
        chk_rs1 = '0;
    endtask

    task automatic test_x0();
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b exp=0", stall); end
        req_valid = 3'b001; req_rd[4:0] = 5'd0; req_data[31:0] = 32'h1234;
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
        step();
        req_valid = '0;
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%b exp=0", rf_we); end
        step();
    endtask

    task automatic test_flush();
        int first1;
        req_rd = {5'd0, 5'd13, 5'd12};
        req_data = {32'h0, 32'hD, 32'h1234};
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd9; req_valid = 3'b011;
        step();
        issue_valid = 1'b0; chk_rs1 = 5'd3; chk_rs2 = 5'd9;
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got=%b exp=1", stall); end
        flush = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd12) begin errors++; $display("FAIL flush_inflight got=%b/%0d exp=1/12", rf_we, rf_rd); end
        step();
        flush = 1'b0;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        // Counter 1 cleared by flush: it must lose exactly four more cycles
        first1 = -1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (first1 < 0 && req_ready[1]) first1 = i;
            step();
        end
        checks++; if (first1 != 4) begin errors++; $display("FAIL flush_cnt first_grant1 got=%0d exp=4", first1); end
        req_valid = '0; chk_rs1 = '0; chk_rs2 = '0;
        step(); step();
    endtask

    task automatic test_mid_reset();
        chk_rs1 = 5'd20; issue_valid = 1'b1; issue_rd = 5'd20;
        step();
        issue_valid = 1'b0;
        req_valid = 3'b001; req_rd[4:0] = 5'd21; req_data[31:0] = 32'hCAFE;
        step();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mrst_pre_we got=%b exp=1", rf_we); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mrst_we got=%b exp=0", rf_we); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mrst_ready got=%b exp=000", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_stall got=%b exp=0", stall); end
        req_valid = '0;
        step();
        rst = 1'b0;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_pend got=%b exp=0", stall); end
        chk_rs1 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_scoreboard();
        test_x0();
        test_flush();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
